// File: rtl/issue_select_rr_pkg.sv
// Shared constants and per-queue presets for the issue selectors.
// The wrap helper keeps circular index arithmetic in one place.
package issue_select_rr_pkg;

    localparam int ISSUE_TAG_W  = 5;
    localparam int ALU_DEPTH    = 7;
    localparam int LS_DEPTH     = 8;
    localparam int MD_DEPTH     = 4;
    localparam int MAX_WAKE_LAT = 4;

    typedef enum logic [1:0] {
        QUEUE_ALU = 2'd0,
        QUEUE_LS  = 2'd1,
        QUEUE_MD  = 2'd2
    } queue_kind_e;

    typedef struct packed {
        logic       rr_mode;
        logic [2:0] wake_lat;
        logic [3:0] busy_cyc;
    } queue_cfg_t;

    localparam queue_cfg_t ALU_CFG = '{rr_mode: 1'b0, wake_lat: 3'd1, busy_cyc: 4'd0};
    localparam queue_cfg_t LS_CFG  = '{rr_mode: 1'b0, wake_lat: 3'd1, busy_cyc: 4'd0};
    localparam queue_cfg_t MD_CFG  = '{rr_mode: 1'b1, wake_lat: 3'd1, busy_cyc: 4'd3};

    function automatic queue_cfg_t queue_cfg(input queue_kind_e kind);
        queue_cfg_t cfg;
        case (kind)
            QUEUE_LS: cfg = LS_CFG;
            QUEUE_MD: cfg = MD_CFG;
            default:  cfg = ALU_CFG;
        endcase
        return cfg;
    endfunction

    // Valid only for base < modulus and offset <= modulus.
    function automatic int wrap_add(input int base, input int offset, input int modulus);
        int sum;
        sum = base + offset;
        if (sum >= modulus) begin
            sum = sum - modulus;
        end
        return sum;
    endfunction

endpackage

// File: rtl/issue_select_rr_pick.sv
// Circular first-one finder: first request not masked, scanning from start
// and wrapping N-1 -> 0.
module pick_first_rr
    import issue_select_rr_pkg::*;
#(
    parameter int N     = 7,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    input  logic [N-1:0]     mask,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [N-1:0] cand;

    assign cand = req & ~mask;

    always_comb begin
        logic [IDX_W-1:0] pos;
        idx   = '0;
        valid = 1'b0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            pos = IDX_W'(wrap_add(int'(start), k, N));
            if (!valid && cand[pos]) begin
                valid = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/issue_select_rr.sv
// N-entry, P-port issue selector with issued tracking, registered grants,
// delayed destination wakeups and per-port occupancy for non-pipelined units.
module issue_select_rr
    import issue_select_rr_pkg::*;
#(
    parameter int ENTRIES  = 7,
    parameter int PORTS    = 2,
    parameter int TAG_W    = ISSUE_TAG_W,
    parameter int IDX_W    = $clog2(ENTRIES),
    parameter int RR_MODE  = 0,
    parameter int WAKE_LAT = 1,
    parameter int BUSY_CYC = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [ENTRIES-1:0]       ent_valid,
    input  logic [ENTRIES-1:0]       ent_rdy,
    input  logic [ENTRIES-1:0]       ent_wr,
    input  logic [ENTRIES*TAG_W-1:0] ent_dst,
    input  logic [ENTRIES-1:0]       ent_alloc,
    input  logic [PORTS-1:0]         fu_stall,
    output logic [PORTS-1:0]         grant_en,
    output logic [PORTS*IDX_W-1:0]   grant_idx,
    output logic [ENTRIES-1:0]       grant_vec,
    output logic [PORTS-1:0]         wake_en,
    output logic [PORTS*TAG_W-1:0]   wake_tag
);

    localparam int CNT_W = (BUSY_CYC > 0) ? $clog2(BUSY_CYC + 1) : 1;

    logic [ENTRIES-1:0]     issued;
    logic [ENTRIES-1:0]     elig;
    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       scan_start;
    logic [IDX_W-1:0]       last_idx;
    logic [CNT_W-1:0]       busy_cnt [PORTS];
    logic [PORTS-1:0]       avail;
    logic [PORTS-1:0]       sel_en;
    logic [PORTS-1:0]       sel_wr;
    logic [IDX_W-1:0]       sel_idx  [PORTS];
    logic [PORTS*TAG_W-1:0] sel_tag;
    logic [ENTRIES-1:0]     taken    [PORTS+1];
    logic [PORTS-1:0]       pipe_en  [WAKE_LAT+1];
    logic [PORTS*TAG_W-1:0] pipe_tag [WAKE_LAT+1];

    assign elig       = ent_valid & ent_rdy & ~issued & ~ent_alloc;
    assign scan_start = (RR_MODE != 0) ? rr_ptr : '0;
    assign taken[0]   = '0;

    // Each port sees the entries not yet claimed by lower ports; an unavailable
    // port requests nothing, so its would-be entry stays with the next port.
    for (genvar p = 0; p < PORTS; p++) begin : g_port
        logic [ENTRIES-1:0] req;
        logic               wr_bit;
        logic [TAG_W-1:0]   dst;

        assign avail[p] = ~fu_stall[p] & (busy_cnt[p] == '0);
        assign req      = avail[p] ? elig : '0;

        pick_first_rr #(
            .N     (ENTRIES),
            .IDX_W (IDX_W)
        ) u_pick (
            .req   (req),
            .start (scan_start),
            .mask  (taken[p]),
            .idx   (sel_idx[p]),
            .valid (sel_en[p])
        );

        assign taken[p+1] = taken[p] | (sel_en[p] ? (ENTRIES'(1) << sel_idx[p]) : '0);

        always_comb begin
            wr_bit = 1'b0;
            dst    = '0;
            for (int i = 0; i < ENTRIES; i++) begin
                if (sel_idx[p] == IDX_W'(i)) begin
                    wr_bit = ent_wr[i];
                    dst    = ent_dst[i*TAG_W +: TAG_W];
                end
            end
        end

        assign sel_wr[p]                   = sel_en[p] & wr_bit;
        assign sel_tag[p*TAG_W +: TAG_W]   = (sel_en[p] & wr_bit) ? dst : '0;
    end

    // Ports claim entries in scan order, so the highest granting port holds the
    // entry furthest along the scan.
    always_comb begin
        last_idx = '0;
        for (int p = 0; p < PORTS; p++) begin
            if (sel_en[p]) begin
                last_idx = sel_idx[p];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issued    <= '0;
            rr_ptr    <= '0;
            grant_en  <= '0;
            grant_idx <= '0;
            grant_vec <= '0;
        end else if (flush) begin
            issued    <= '0;
            grant_en  <= '0;
            grant_idx <= '0;
            grant_vec <= '0;
        end else begin
            issued    <= (issued | taken[PORTS]) & ~ent_alloc;
            grant_en  <= sel_en;
            grant_vec <= taken[PORTS];
            for (int p = 0; p < PORTS; p++) begin
                grant_idx[p*IDX_W +: IDX_W] <= sel_en[p] ? sel_idx[p] : '0;
            end
            if ((RR_MODE != 0) && (|sel_en)) begin
                rr_ptr <= IDX_W'(wrap_add(int'(last_idx), 1, ENTRIES));
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < PORTS; p++) begin
            if (rst || flush) begin
                busy_cnt[p] <= '0;
            end else if (sel_en[p] && (BUSY_CYC > 0)) begin
                busy_cnt[p] <= CNT_W'(BUSY_CYC);
            end else if (busy_cnt[p] != '0) begin
                busy_cnt[p] <= busy_cnt[p] - CNT_W'(1);
            end
        end
    end

    // Stage 0 lines up with the grant registers; WAKE_LAT more stages follow.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int s = 0; s <= WAKE_LAT; s++) begin
                pipe_en[s]  <= '0;
                pipe_tag[s] <= '0;
            end
        end else begin
            pipe_en[0]  <= sel_wr;
            pipe_tag[0] <= sel_tag;
            for (int s = 1; s <= WAKE_LAT; s++) begin
                pipe_en[s]  <= pipe_en[s-1];
                pipe_tag[s] <= pipe_tag[s-1];
            end
        end
    end

    assign wake_en  = pipe_en[WAKE_LAT];
    assign wake_tag = pipe_tag[WAKE_LAT];

endmodule

// File: doc/issue_select_rr.md
Name: issue_select_rr

Overview:
- Parametrised N-entry, P-port issue selector for one issue queue (ALU, LS or MD).
- Picks up to P ready, not-yet-issued entries per cycle, with fixed-priority or round-robin order.
- Tracks per-entry issued state internally and registers the grants.
- Broadcasts destination-tag wakeups after a configurable latency; holds non-pipelined ports busy for a configurable occupancy.

Parameters:
- ENTRIES, 7, number of queue entries (N >= 2).
- PORTS, 2, grant ports per cycle (1 <= P <= N).
- TAG_W, 5, destination physical-register tag width.
- IDX_W, $clog2(ENTRIES), entry index width.
- RR_MODE, 0, 0 = lowest index first; 1 = round-robin starting at rr_ptr.
- WAKE_LAT, 1, cycles from grant output to wakeup output (0..4).
- BUSY_CYC, 0, extra cycles a port refuses new grants after granting; 0 = fully pipelined.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  squash: clears issued bits, wakeup pipe and busy counters.
- ent_valid  in  N  entry holds an instruction.
- ent_rdy  in  N  all source operands ready.
- ent_wr  in  N  entry writes a destination register.
- ent_dst  in  N*TAG_W  destination tags, entry i at [i*TAG_W +: TAG_W].
- ent_alloc  in  N  entry (re)written this cycle; clears its issued bit.
- fu_stall  in  P  port p must not grant this cycle.
- grant_en  out  P  registered grant valid per port.
- grant_idx  out  P*IDX_W  registered granted entry index per port.
- grant_vec  out  N  registered one-hot-per-port OR of granted entries.
- wake_en  out  P  wakeup valid per port.
- wake_tag  out  P*TAG_W  wakeup tag per port.

Behaviour:
- Reset: all outputs 0; issued bits, rr_ptr, wakeup pipe and busy counters all 0.
- Eligibility: elig[i] = ent_valid & ent_rdy & ~issued & ~ent_alloc.
- Ordering:
  - RR_MODE=0 scans from index 0 upward.
  - RR_MODE=1 scans from rr_ptr, wrapping N-1 -> 0.
- Port assignment:
  - Lowest-numbered available port takes the first eligible entry in scan order, the next available port the second, and so on.
  - A port is available when fu_stall[p]=0 and busy_cnt[p]=0.
  - Unavailable ports are skipped; entries do not shift to them.
  - A given entry is never granted on two ports in one cycle.
- Latency: selection is combinational on cycle t; grant_en/grant_idx/grant_vec are registered and visible on t+1.
  - Unused ports on t+1: grant_en=0, grant_idx=0.
- Issued bits: set at the same edge that registers the grant, so an entry is never re-granted.
  - Cleared by ent_alloc[i], flush or rst.
  - ent_alloc has priority over a simultaneous set.
- rr_ptr (RR_MODE=1 only): at an edge with at least one grant, rr_ptr <= (last entry granted in scan order + 1) mod N. Unchanged if there is no grant.
- Busy: when port p grants and BUSY_CYC>0, busy_cnt[p] <= BUSY_CYC; it decrements to 0 each cycle. BUSY_CYC=0 never blocks.
- Wakeup: wake_en[p] = grant_en[p] & ent_wr[idx] sampled at selection, delayed WAKE_LAT cycles through a P-wide shift pipe.
  - wake_tag carries the dst tag captured at selection.
  - WAKE_LAT=0 makes wakeup coincident with the grant output.
  - Wakeup tag is 0 when wake_en=0.
- Flush:
  - At the flush edge: grants register as 0, wakeup pipe and busy counters clear, issued bits clear. rr_ptr is kept.
  - Grants computed in the flush cycle are discarded.
- No eligible entries: all grant_en=0, no state change except busy decrement and pipe shift.
- rst mid-operation: identical to reset; in-flight wakeups are dropped.

Decomposition:
- Shared package: ISSUE_TAG_W, queue-depth constants, per-queue RR_MODE/WAKE_LAT/BUSY_CYC presets (ALU: 0/1/0, LS: 0/1/0, MD: 1/1/3).
- One sub-module: pick_first_rr (N-bit request, start pointer, mask -> first index + valid). Instantiate it P times, masking prior picks.

Test Plan:
- Fixed priority: N=7, P=2, RR_MODE=0, elig entries {2,5,6} -> next cycle grant_idx={2,5}, grant_vec=0100100; following cycle grant_idx[0]=6, grant_en=01; then no grants.
- Round-robin: RR_MODE=1, all 7 entries elig and re-allocated each cycle, P=1 -> grants 0,1,2,...,6,0 in successive cycles.
- Stall/busy: P=1, BUSY_CYC=3, entries 0 and 1 elig -> grant 0 at t+1; entry 1 granted at t+5 (4 cycles later). fu_stall high at t blocks the grant and entry 0 waits.
- Wakeup latency: WAKE_LAT=2, entry 3 with ent_wr=1, dst=5'd17 -> grant at t+1, wake_en=1 and wake_tag=17 at t+3. With ent_wr=0, no wakeup.
- Flush: grant issued at t+1 with WAKE_LAT=2, flush at t+1 -> no wakeup at t+3, issued bits cleared, entry regranted after flush deasserts.
- Alloc vs issued: entry 4 granted, ent_alloc[4] on the same edge as a new select -> issued[4]=0, entry 4 regranted once rdy again.
